// File: rtl/imem_load_ctrl.sv
// imem_load_ctrl
// Boot sequencer that loads a program from the instruction transmitter into
// instruction memory and holds the MIPS pipeline in reset until the load is
// complete.
//
// Ports
//   ld_clk, ld_rst      : clock (rising edge), asynchronous active-high reset
//   ld_i_start          : one-cycle pulse that starts or restarts a load
//   ld_o_syn            : sync request to the transmitter, high while loading
//   ld_i_instr/ack/last : transmitter word, its valid strobe, final-word flag
//   ld_o_we/waddr/wdata : instruction-memory write port (registered)
//   ld_o_cpu_rst        : CPU reset hold, released once a program has loaded
//   ld_o_done/err       : load completed / load failed (timeout or overflow)
//   ld_o_count          : words written in the current or most recent load
module imem_load_ctrl #(
  parameter int IWIDTH  = 32,
  parameter int DEPTH   = 6,
  parameter int AWIDTH  = 3,
  parameter int TIMEOUT = 16
) (
  input  logic              ld_clk,
  input  logic              ld_rst,
  input  logic              ld_i_start,
  output logic              ld_o_syn,
  input  logic [IWIDTH-1:0] ld_i_instr,
  input  logic              ld_i_ack,
  input  logic              ld_i_last,
  output logic              ld_o_we,
  output logic [AWIDTH-1:0] ld_o_waddr,
  output logic [IWIDTH-1:0] ld_o_wdata,
  output logic              ld_o_cpu_rst,
  output logic              ld_o_done,
  output logic              ld_o_err,
  output logic [AWIDTH:0]   ld_o_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  // Wide enough to hold the value TIMEOUT itself.
  localparam int TOW = $clog2(TIMEOUT + 1);

  logic [1:0]        state_q,   state_d;
  logic              syn_q,     syn_d;
  logic              we_q,      we_d;
  logic [AWIDTH-1:0] waddr_q,   waddr_d;
  logic [IWIDTH-1:0] wdata_q,   wdata_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              done_q,    done_d;
  logic              err_q,     err_d;
  logic [AWIDTH:0]   count_q,   count_d;
  logic [TOW-1:0]    tmo_q,     tmo_d;

  logic [AWIDTH:0]   count_inc;
  logic [TOW-1:0]    tmo_inc;

  assign count_inc = count_q + 1'b1;
  assign tmo_inc   = tmo_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    syn_d     = syn_q;
    we_d      = 1'b0;  // write strobe lasts exactly one cycle per word
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    cpu_rst_d = cpu_rst_q;
    done_d    = done_q;
    err_d     = err_q;
    count_d   = count_q;
    tmo_d     = tmo_q;

    if (state_q == S_LOAD) begin
      if (ld_i_ack) begin
        we_d    = 1'b1;
        waddr_d = count_q[AWIDTH-1:0];
        wdata_d = ld_i_instr;
        count_d = count_inc;
        tmo_d   = '0;
        if (ld_i_last) begin
          // CPU is released on the same edge the final write is issued.
          state_d   = S_DONE;
          syn_d     = 1'b0;
          cpu_rst_d = 1'b0;
          done_d    = 1'b1;
        end else if (count_inc == (AWIDTH + 1)'(DEPTH)) begin
          // Memory is full but the transmitter has more: overflow.
          state_d = S_ERR;
          syn_d   = 1'b0;
          err_d   = 1'b1;
        end
      end else begin
        tmo_d = tmo_inc;
        if (tmo_inc == TOW'(TIMEOUT)) begin
          state_d = S_ERR;
          syn_d   = 1'b0;
          err_d   = 1'b1;
        end
      end
    end else if (ld_i_start) begin
      // Start from IDLE, DONE or ERR begins a fresh load at address 0.
      state_d   = S_LOAD;
      syn_d     = 1'b1;
      waddr_d   = '0;
      cpu_rst_d = 1'b1;
      done_d    = 1'b0;
      err_d     = 1'b0;
      count_d   = '0;
      tmo_d     = '0;
    end
  end

  always_ff @(posedge ld_clk or posedge ld_rst) begin
    if (ld_rst) begin
      state_q   <= S_IDLE;
      syn_q     <= 1'b0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      count_q   <= '0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      syn_q     <= syn_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      cpu_rst_q <= cpu_rst_d;
      done_q    <= done_d;
      err_q     <= err_d;
      count_q   <= count_d;
      tmo_q     <= tmo_d;
    end
  end

  assign ld_o_syn     = syn_q;
  assign ld_o_we      = we_q;
  assign ld_o_waddr   = waddr_q;
  assign ld_o_wdata   = wdata_q;
  assign ld_o_cpu_rst = cpu_rst_q;
  assign ld_o_done    = done_q;
  assign ld_o_err     = err_q;
  assign ld_o_count   = count_q;

endmodule
